dp_ram_ctrl: RTL and testbench

- Parametrised, single-clock, true-dual-port RAM block with byte-write enables and a configurable registered read pipeline.
- Selectable read-first or write-first port behaviour.
- Hardware clear sequencer that zeroes the array after reset, plus same-cycle port-collision detection.
- Next-generation replacement for the fixed 16x1024 dual-port memory-plus-output-register arrangement; sits between datapath masters and on-chip block RAM.

---
 rtl/dp_ram_ctrl_if.sv | 37 +++
 rtl/dp_ram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dp_ram_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dp_ram_ctrl_if.sv
// Port bundle for dp_ram_ctrl: two independent access ports plus status outputs.
// The master drives the access requests and the slave (the RAM block) returns the read data and status.
interface dp_ram_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic                  ena;
    logic                  wea;
    logic [DATA_W/8-1:0]   bea;
    logic [ADDR_W-1:0]     addra;
    logic [DATA_W-1:0]     dina;
    logic [DATA_W-1:0]     douta;
    logic                  douta_vld;

    logic                  enb;
    logic                  web;
    logic [DATA_W/8-1:0]   beb;
    logic [ADDR_W-1:0]     addrb;
    logic [DATA_W-1:0]     dinb;
    logic [DATA_W-1:0]     doutb;
    logic                  doutb_vld;

    logic                  collision;
    logic                  init_done;

    modport master (
        output ena, wea, bea, addra, dina,
        output enb, web, beb, addrb, dinb,
        input  douta, douta_vld, doutb, doutb_vld, collision, init_done
    );

    modport slave (
        input  ena, wea, bea, addra, dina,
        input  enb, web, beb, addrb, dinb,
        output douta, douta_vld, doutb, doutb_vld, collision, init_done
    );
endinterface

// File: rtl/dp_ram_ctrl.sv
// True-dual-port RAM with byte enables, 1- or 2-cycle registered read, selectable read-/write-first
// same-port behaviour, a post-reset clear sequencer and same-address collision flag.
module dp_ram_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int RD_LAT         = 1,
    parameter int WR_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    dp_ram_ctrl_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              collision_q, collision_d;

    logic              run;
    logic              wr_a, wr_b, same;
    logic [DATA_W-1:0] old_a, old_b, pre_a, post_b;
    logic [DATA_W-1:0] douta_p1_d, doutb_p1_d;
    logic              vlda_p1_d, vldb_p1_d;

    // Port accesses only count in RUN and never while reset is held.
    assign run       = reset_n && (state_q == S_RUN);
    assign vlda_p1_d = run && bus.ena;
    assign vldb_p1_d = run && bus.enb;
    assign wr_a      = vlda_p1_d && bus.wea;
    assign wr_b      = vldb_p1_d && bus.web;
    assign same      = (bus.addra == bus.addrb);
    assign old_a     = mem[bus.addra];
    assign old_b     = mem[bus.addrb];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = S_RUN;
        end
        init_done_d = (state_d == S_RUN);
        collision_d = vlda_p1_d && vldb_p1_d && same && (bus.wea || bus.web);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            collision_q <= collision_d;
        end
    end

    // Port A wins any byte both ports write at the same address.
    always_ff @(posedge clk) begin
        if (reset_n && state_q == S_CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && bus.beb[i] && !(wr_a && same && bus.bea[i]))
                    mem[bus.addrb][8*i +: 8] <= bus.dinb[8*i +: 8];
                if (wr_a && bus.bea[i])
                    mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
            end
        end
    end

    // A reading port always sees the pre-write word; only a writing port may see its own update.
    always_comb begin
        pre_a      = (wr_b && same) ? byte_merge(old_a, bus.dinb, bus.beb) : old_a;
        douta_p1_d = old_a;
        if (WR_MODE != 0 && wr_a) douta_p1_d = byte_merge(pre_a, bus.dina, bus.bea);

        post_b     = byte_merge(old_b, bus.dinb, bus.beb);
        if (wr_a && same) post_b = byte_merge(post_b, bus.dina, bus.bea);
        doutb_p1_d = old_b;
        if (WR_MODE != 0 && wr_b) doutb_p1_d = post_b;
    end

    // ---- stage p1 (only present with two-cycle read latency) ----
    logic [DATA_W-1:0] src_a, src_b;
    logic              src_vld_a, src_vld_b;

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] douta_p1_q, doutb_p1_q;
        logic              vlda_p1_q, vldb_p1_q;

        always_ff @(posedge clk) begin
            douta_p1_q <= douta_p1_d;
            doutb_p1_q <= doutb_p1_d;
            if (!reset_n) begin
                vlda_p1_q <= 1'b0;
                vldb_p1_q <= 1'b0;
            end else begin
                vlda_p1_q <= vlda_p1_d;
                vldb_p1_q <= vldb_p1_d;
            end
        end

        assign src_a     = douta_p1_q;
        assign src_b     = doutb_p1_q;
        assign src_vld_a = vlda_p1_q;
        assign src_vld_b = vldb_p1_q;
    end else begin : g_lat1
        assign src_a     = douta_p1_d;
        assign src_b     = doutb_p1_d;
        assign src_vld_a = vlda_p1_d;
        assign src_vld_b = vldb_p1_d;
    end

    // ---- output stage: holds last result between strobes ----
    logic [DATA_W-1:0] douta_q, douta_d, doutb_q, doutb_d;
    logic              douta_vld_q, douta_vld_d, doutb_vld_q, doutb_vld_d;

    always_comb begin
        douta_d     = src_vld_a ? src_a : douta_q;
        doutb_d     = src_vld_b ? src_b : doutb_q;
        douta_vld_d = src_vld_a;
        doutb_vld_d = src_vld_b;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            douta_q     <= '0;
            doutb_q     <= '0;
            douta_vld_q <= 1'b0;
            doutb_vld_q <= 1'b0;
        end else begin
            douta_q     <= douta_d;
            doutb_q     <= doutb_d;
            douta_vld_q <= douta_vld_d;
            doutb_vld_q <= doutb_vld_d;
        end
    end

    assign bus.douta     = douta_q;
    assign bus.doutb     = doutb_q;
    assign bus.douta_vld = douta_vld_q;
    assign bus.doutb_vld = doutb_vld_q;
    assign bus.collision = collision_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Directed bench for dp_ram_ctrl: three instances (lat1/read-first, lat2/write-first, no-clear)
// share one stimulus stream; each step compares against hand-computed values.
module tb_dp_ram_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ena, wea, enb, web;
    logic [1:0]  bea, beb;
    logic [3:0]  addra, addrb;
    logic [15:0] dina, dinb;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dp_ram_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_drv
        assign bus[g].ena   = ena;
        assign bus[g].wea   = wea;
        assign bus[g].bea   = bea;
        assign bus[g].addra = addra;
        assign bus[g].dina  = dina;
        assign bus[g].enb   = enb;
        assign bus[g].web   = web;
        assign bus[g].beb   = beb;
        assign bus[g].addrb = addrb;
        assign bus[g].dinb  = dinb;
    end

    dp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .WR_MODE(0), .CLEAR_ON_RESET(1))
        u_lat1 (.clk(clk), .reset_n(reset_n), .bus(bus[0]));
    dp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .WR_MODE(1), .CLEAR_ON_RESET(1))
        u_lat2 (.clk(clk), .reset_n(reset_n), .bus(bus[1]));
    dp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .WR_MODE(0), .CLEAR_ON_RESET(0))
        u_noclr (.clk(clk), .reset_n(reset_n), .bus(bus[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; bea = 2'b11; addra = '0; dina = '0;
        enb = 1'b0; web = 1'b0; beb = 2'b11; addrb = '0; dinb = '0;
    endtask

    task automatic wr_port_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d; bea = be;
    endtask

    task automatic rd_port_a(input logic [3:0] a);
        ena = 1'b1; wea = 1'b0; addra = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Counts edges after reset release until both clearing instances report init_done.
    task automatic wait_init(output int l0, output int l1, output int l2, output logic saw);
        l0 = -1; l1 = -1; l2 = -1; saw = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (l0 < 0 && bus[0].init_done) l0 = c;
            if (l1 < 0 && bus[1].init_done) l1 = c;
            if (l2 < 0 && bus[2].init_done) l2 = c;
            if (!bus[0].init_done && (bus[0].douta_vld || bus[0].doutb_vld || bus[0].collision))
                saw = 1'b1;
            if (!bus[1].init_done && (bus[1].douta_vld || bus[1].doutb_vld || bus[1].collision))
                saw = 1'b1;
            if (l0 >= 0 && l1 >= 0) begin
                idle();
                break;
            end
        end
        idle();
    endtask

    initial begin
        int   l0, l1, l2;
        logic saw;

        idle();
        reset_n = 1'b0;
        tick(); tick(); tick();
        chk("rst_douta",      {16'h0, bus[0].douta}, 32'h0);
        chk("rst_douta_vld",  {31'h0, bus[0].douta_vld}, 32'h0);
        chk("rst_collision",  {31'h0, bus[0].collision}, 32'h0);
        chk("rst_init_done",  {31'h0, bus[0].init_done}, 32'h0);
        chk("rst_init_noclr", {31'h0, bus[2].init_done}, 32'h0);

        // Release reset while trying to write addr 3 during the clear.
        reset_n = 1'b1;
        wr_port_a(4'd3, 16'hFFFF, 2'b11);
        wait_init(l0, l1, l2, saw);
        chk("clr_latency_lat1", l0, 32'd16);
        chk("clr_latency_lat2", l1, 32'd16);
        chk("init_latency_noclr", l2, 32'd1);
        chk("clr_quiet", {31'h0, saw}, 32'h0);

        for (int a = 0; a < 16; a++) begin
            rd_port_a(a[3:0]);
            tick();
            chk($sformatf("clr_rd1_a%0d", a), {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b1, 16'h0000});
            if (a > 0)
                chk($sformatf("clr_rd2_a%0d", a - 1), {15'h0, bus[1].douta_vld, bus[1].douta}, {15'h0, 1'b1, 16'h0000});
        end
        idle();
        tick();
        chk("stream_end_lat1", {31'h0, bus[0].douta_vld}, 32'h0);
        chk("stream_end_lat2", {15'h0, bus[1].douta_vld, bus[1].douta}, {15'h0, 1'b1, 16'h0000});

        // Read latency
        wr_port_a(4'd5, 16'hBEEF, 2'b11);
        tick();
        idle();
        tick(); tick();
        rd_port_a(4'd5);
        tick();
        chk("lat1_hit",   {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b1, 16'hBEEF});
        chk("lat2_early", {31'h0, bus[1].douta_vld}, 32'h0);
        idle();
        tick();
        chk("lat1_hold",  {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b0, 16'hBEEF});
        chk("lat2_hit",   {15'h0, bus[1].douta_vld, bus[1].douta}, {15'h0, 1'b1, 16'hBEEF});
        tick();
        chk("lat2_hold",  {15'h0, bus[1].douta_vld, bus[1].douta}, {15'h0, 1'b0, 16'hBEEF});

        // Byte enables and same-port write mode
        wr_port_a(4'd2, 16'h1234, 2'b11);
        tick();
        wr_port_a(4'd2, 16'hABCD, 2'b10);
        tick();
        chk("be_wm0_old", {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b1, 16'h1234});
        idle();
        tick();
        chk("be_wm1_new", {15'h0, bus[1].douta_vld, bus[1].douta}, {15'h0, 1'b1, 16'hAB34});
        rd_port_a(4'd2);
        tick();
        chk("be_merge",   {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b1, 16'hAB34});
        idle();
        tick();

        wr_port_a(4'd7, 16'h1111, 2'b11);
        tick();
        wr_port_a(4'd7, 16'h2222, 2'b11);
        tick();
        chk("wm0_old",    {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b1, 16'h1111});
        idle();
        tick();
        chk("wm1_new",    {15'h0, bus[1].douta_vld, bus[1].douta}, {15'h0, 1'b1, 16'h2222});
        tick();

        // Cross-port conflicts
        wr_port_a(4'd9, 16'hAAAA, 2'b01);
        enb = 1'b1; web = 1'b1; addrb = 4'd9; dinb = 16'h5555; beb = 2'b11;
        tick();
        chk("coll_ww",    {31'h0, bus[0].collision}, 32'h1);
        idle();
        tick();
        chk("coll_pulse", {31'h0, bus[0].collision}, 32'h0);
        rd_port_a(4'd9);
        tick();
        chk("ww_merge",   {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b1, 16'h55AA});
        idle();
        tick();

        wr_port_a(4'd4, 16'h1234, 2'b11);
        enb = 1'b1; web = 1'b0; addrb = 4'd4;
        tick();
        chk("coll_wr",    {31'h0, bus[0].collision}, 32'h1);
        chk("wr_rd_old1", {15'h0, bus[0].doutb_vld, bus[0].doutb}, {15'h0, 1'b1, 16'h0000});
        idle();
        tick();
        chk("wr_rd_old2", {15'h0, bus[1].doutb_vld, bus[1].doutb}, {15'h0, 1'b1, 16'h0000});
        chk("wr_rd_own2", {15'h0, bus[1].douta_vld, bus[1].douta}, {15'h0, 1'b1, 16'h1234});

        rd_port_a(4'd4);
        enb = 1'b1; web = 1'b0; addrb = 4'd4;
        tick();
        chk("coll_rr",    {31'h0, bus[0].collision}, 32'h0);
        chk("rr_a",       {16'h0, bus[0].douta}, {16'h0, 16'h1234});
        chk("rr_b",       {16'h0, bus[0].doutb}, {16'h0, 16'h1234});
        idle();
        tick();

        // Reset during an in-flight two-cycle read
        rd_port_a(4'd5);
        tick();
        reset_n = 1'b0;
        idle();
        tick();
        chk("rst_drop_lat2", {31'h0, bus[1].douta_vld}, 32'h0);
        chk("rst_mid_douta", {16'h0, bus[0].douta}, 32'h0);
        chk("rst_mid_init",  {31'h0, bus[0].init_done}, 32'h0);
        reset_n = 1'b1;
        wait_init(l0, l1, l2, saw);
        chk("reclr_latency_lat1", l0, 32'd16);
        chk("reclr_latency_lat2", l1, 32'd16);
        chk("reclr_quiet", {31'h0, saw}, 32'h0);
        rd_port_a(4'd5);
        tick();
        chk("reclr_a5", {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b1, 16'h0000});
        rd_port_a(4'd9);
        tick();
        chk("reclr_a9", {15'h0, bus[0].douta_vld, bus[0].douta}, {15'h0, 1'b1, 16'h0000});
        idle();
        tick();

        // Reset in the middle of a clear restarts it from address 0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_init(l0, l1, l2, saw);
        chk("midclr_latency", l0, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
